// File: rtl/mul6_err_pkg.sv
// mul6_err_pkg: shared types and default sizing for the mul6 error-metric
// accumulator.
//   err_state_t  - sweep FSM states (IDLE, RUN, DRAIN, DONE)
//   err_sample_t - one operand pair with its approximate and exact product
//   DEF_*        - default parameter values used by mul6_err_accum
package mul6_err_pkg;

    localparam int DEF_W         = 6;
    localparam int DEF_N_SAMPLES = 4096;
    localparam int DEF_CNT_W     = 13;
    localparam int DEF_SUM_W     = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } err_state_t;

    typedef struct packed {
        logic [DEF_W-1:0]   a;
        logic [DEF_W-1:0]   b;
        logic [2*DEF_W-1:0] apx;
        logic [2*DEF_W-1:0] exact;
    } err_sample_t;

endpackage

// File: rtl/mul6_err_accum_sat_accum.sv
// sat_accum: clearable accumulator register that saturates instead of
// wrapping. Unsigned mode clamps at all-ones; signed mode clamps at the
// most positive / most negative WIDTH-bit values.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clr         - synchronous clear (wins over en)
//   en          - add 'add' into the accumulator this cycle
//   add [IN_W]  - addend, interpreted with the same signedness as acc
//   acc [WIDTH] - accumulated value
module sat_accum #(
    parameter int WIDTH  = 24,
    parameter int IN_W   = 12,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  add,
    output logic [WIDTH-1:0] acc
);

    // One guard bit above the wider operand: the raw sum can never overflow,
    // so range checking is a look at the top bits.
    localparam int EW = ((IN_W > WIDTH) ? IN_W : WIDTH) + 1;

    logic [EW-1:0]    acc_x, add_x, sum;
    logic [WIDTH-1:0] nxt;
    logic             in_rng;

    always_comb begin
        acc_x = {{(EW-WIDTH){SIGNED & acc[WIDTH-1]}}, acc};
        add_x = {{(EW-IN_W){SIGNED & add[IN_W-1]}}, add};
        sum   = acc_x + add_x;
        if (SIGNED) begin
            // In range when every bit from the result MSB upward agrees.
            in_rng = (&sum[EW-1:WIDTH-1]) | ~(|sum[EW-1:WIDTH-1]);
            nxt    = sum[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            in_rng = ~(|sum[EW-1:WIDTH]);
            nxt    = '1;
        end
        if (in_rng) nxt = sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= nxt;
    end

endmodule

// File: rtl/mul6_err_accum.sv
// mul6_err_accum: streaming error-metric accumulator for a WxW approximate
// multiplier. Each accepted sample (a, b, approximate product) is compared
// against the exact product; over a sweep of N_SAMPLES samples the block
// collects the mismatch count, the maximum absolute error with its operands
// and the (saturating) sum of absolute errors.
// Optional feature: define MUL6_ERR_SIGNED_SUM_EN to add the signed bias
// accumulator sum_err (saturating at both extremes).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start                    - clear statistics and (re)arm a sweep
//   in_valid/in_ready        - sample handshake; in_ready only in RUN
//   in_a, in_b, in_p_apx     - operands and approximate product
//   busy, done               - RUN/DRAIN, DONE (held until next start)
//   err_cnt                  - samples whose product mismatched
//   max_abs_err, max_a/max_b - largest |exact-apx| and first pair reaching it
//   sum_abs_err              - saturating sum of |exact-apx|
//   sum_err                  - saturating signed sum of (apx-exact), optional
module mul6_err_accum
    import mul6_err_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SUM_W     = DEF_SUM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic [2*W-1:0]      in_p_apx,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [2*W-1:0]      max_abs_err,
    output logic [W-1:0]        max_a,
    output logic [W-1:0]        max_b,
`ifdef MUL6_ERR_SIGNED_SUM_EN
    output logic [SUM_W-1:0]    sum_abs_err,
    output logic signed [SUM_W:0] sum_err
`else
    output logic [SUM_W-1:0]    sum_abs_err
`endif
);

    localparam int PW = 2 * W;

    err_state_t       state, state_nxt;
    logic             accept, last, acc_en;
    logic [CNT_W-1:0] smp_cnt;
    logic [2:1]       vld_pipe;

    // S1 / S2 pipeline registers
    logic [W-1:0]  a1, b1, a2, b2;
    logic [PW-1:0] apx1, exact1, mag2;
    logic          mis2;
`ifdef MUL6_ERR_SIGNED_SUM_EN
    logic [PW:0]   d2;
`endif

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign last     = (smp_cnt == CNT_W'(N_SAMPLES - 1));
    // A start in the same cycle as an S2 sample discards that sample.
    assign acc_en   = vld_pipe[2] && !start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (accept && last) state_nxt = DRAIN;
                // S1 empty here means the last sample is in S2 and lands
                // on this edge, so DRAIN always lasts exactly two cycles.
                DRAIN:   if (!vld_pipe[1]) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         smp_cnt <= '0;
        else if (start)  smp_cnt <= '0;
        else if (accept) smp_cnt <= smp_cnt + 1'b1;
    end

    // ---------------- pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a1 <= '0; b1 <= '0; apx1 <= '0; exact1 <= '0;
            a2 <= '0; b2 <= '0; mag2 <= '0; mis2 <= 1'b0;
        end else begin
            vld_pipe[1] <= accept && !start;
            vld_pipe[2] <= vld_pipe[1] && !start;
            if (accept) begin
                a1     <= in_a;
                b1     <= in_b;
                apx1   <= in_p_apx;
                exact1 <= PW'(in_a) * PW'(in_b);
            end
            if (vld_pipe[1]) begin
                a2   <= a1;
                b2   <= b1;
                mag2 <= (apx1 >= exact1) ? (apx1 - exact1) : (exact1 - apx1);
                mis2 <= (apx1 != exact1);
            end
        end
    end

`ifdef MUL6_ERR_SIGNED_SUM_EN
    // Signed difference only feeds the bias accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              d2 <= '0;
        else if (vld_pipe[1]) d2 <= {1'b0, apx1} - {1'b0, exact1};
    end
`endif

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst || start) begin
            err_cnt     <= '0;
            max_abs_err <= '0;
            max_a       <= '0;
            max_b       <= '0;
        end else if (acc_en) begin
            err_cnt <= err_cnt + CNT_W'(mis2);
            // Strict compare: ties keep the earliest operand pair.
            if (mag2 > max_abs_err) begin
                max_abs_err <= mag2;
                max_a       <= a2;
                max_b       <= b2;
            end
        end
    end

    sat_accum #(.WIDTH(SUM_W), .IN_W(PW), .SIGNED(1'b0)) u_sum_abs (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (acc_en),
        .add (mag2),
        .acc (sum_abs_err)
    );

`ifdef MUL6_ERR_SIGNED_SUM_EN
    logic [SUM_W:0] sum_err_raw;

    sat_accum #(.WIDTH(SUM_W + 1), .IN_W(PW + 1), .SIGNED(1'b1)) u_sum_err (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (acc_en),
        .add (d2),
        .acc (sum_err_raw)
    );

    assign sum_err = $signed(sum_err_raw);
`endif

endmodule
